prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Top-level run controller for the fetch unit and core. Steps through a fixed table of NUM_PROGS programs. For each program it:
- loads the program's start PC,
- pulses Init to the fetch unit,
- watches the core's DONE flag with a watchdog,
- reports cycle count and status to the test harness over a Req/Ack handshake.

It removes the hard-coded program-boundary PCs from the fetch path.

## Interface
Parameters:
- NUM_PROGS, 3: number of programs, 1..4
- START_PC0 / START_PC1 / START_PC2 / START_PC3, 0 / 124 / 301 / 0: 16-bit start PC per program index
- INIT_CYCLES, 2: cycles Init is held high per launch, 1..15
- TIMEOUT, 1000: RUN-state cycle limit, 1..65535

Ports:
- CLK  in  1  clock; all state changes on posedge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  1  harness request to launch the next program (level, sampled in IDLE)
- Core_done  in  1  DONE from fetch unit/core (level, may be sticky)
- Init  out  1  to fetch unit; high while launching
- Start_PC  out  16  PC the fetch unit loads during Init
- Prog_idx  out  2  index of current/next program
- Busy  out  1  high in INIT, RUN, REPORT
- Ack  out  1  one-cycle pulse: program finished or timed out
- Timeout  out  1  status of last program: 1 = watchdog expired
- Cycles  out  16  RUN cycle count of last program
- All_done  out  1  all NUM_PROGS programs complete

## Operation
- States: IDLE, INIT, RUN, REPORT, FINISHED. Outputs are registered or decoded from registered state only; no combinational path from inputs.
- Reset (Reset_n=0, asynchronous) produces:
  - state=IDLE
  - Init=0, Busy=0, Ack=0, Timeout=0, All_done=0
  - Cycles=0, Prog_idx=0
  - Start_PC=START_PC0
- Start_PC = START_PC[Prog_idx] at all times.
- IDLE:
  - If Req=1, go to INIT; clear the init counter and the run counter.
  - Req held high launches programs back to back.
- INIT:
  - Init=1 and Busy=1 for exactly INIT_CYCLES cycles, then go to RUN.
  - Core_done is ignored, so a stale sticky DONE from the previous program cannot end a run.
- RUN (Init=0, Busy=1):
  - Each cycle the run counter increments; the first RUN cycle counts as 1.
  - If Core_done=1: latch Cycles=count, Timeout=0, go to REPORT.
  - Else if count==TIMEOUT: latch Cycles=TIMEOUT, Timeout=1, go to REPORT.
  - If Core_done and count==TIMEOUT occur together, Core_done wins (Timeout=0).
- REPORT: Ack=1 for one cycle.
  - If Prog_idx==NUM_PROGS-1: go to FINISHED; Prog_idx stays.
  - Else: Prog_idx+1, go to IDLE.
- FINISHED:
  - All_done=1, Busy=0; Req ignored.
  - Held until reset; Cycles, Timeout and Prog_idx stay at their last values.
- Cycles and Timeout change only on the REPORT entry edge. They hold between programs.
- Counter widths:
  - run counter 16 bits; cannot overflow because TIMEOUT ≤ 65535
  - init counter 4 bits
- Reset mid-operation (any state): immediate return to reset values. No Ack is issued for the aborted program.

## Timing
- Req=1 sampled at edge k (state IDLE): Init=1 in cycles k..k+INIT_CYCLES-1, i.e. after edges k through k+INIT_CYCLES-1.
- State is RUN from edge k+INIT_CYCLES.
- Core_done sampled high at edge m during RUN:
  - Ack=1 and Cycles/Timeout valid after edge m, for one cycle.
  - Prog_idx and Start_PC update at edge m+1.
- Minimum launch-to-launch spacing with Req held: INIT_CYCLES + RUN cycles + 2.
- Start_PC is stable from IDLE through REPORT of the same program. It is valid at every Init-sampling edge.
- Reset deassertion has no synchronizer in this block; the top level provides one.

## Test plan
- Reset values: hold Reset_n=0 then release, Req=0 -> Init=0, Busy=0, Ack=0, Prog_idx=0, Start_PC=0, Cycles=0, All_done=0 for 10 cycles.
- Single launch: Req pulse 1 cycle, Core_done rises 10th RUN cycle -> Init high exactly 2 cycles, Start_PC=0, one Ack pulse, Cycles=10, Timeout=0, Prog_idx=1, Start_PC=124.
- Stale DONE: Core_done held 1 through INIT, dropped at RUN start, reasserted 5th RUN cycle -> no early finish; Cycles=5.
- Watchdog: TIMEOUT=20, Core_done never asserted -> Ack after 20 RUN cycles, Timeout=1, Cycles=20. Separately, Core_done at RUN cycle 20 -> Timeout=0, Cycles=20.
- Back-to-back: Req held high, Core_done after 3 RUN cycles each -> Start_PC 0, 124, 301 in order; three Ack pulses; All_done=1, Prog_idx=2; further Req causes no Init.
- Reset mid-RUN: assert Reset_n=0 at RUN cycle 4 of program 1 -> outputs return to reset values asynchronously; no Ack; next launch uses Start_PC=0.

Source files
------------

// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: harness/fetch-side bundle for the program run controller.
// master = test harness and fetch unit/core; slave = prog_sequencer.
interface prog_sequencer_if;
  logic        Req;
  logic        Core_done;
  logic        Init;
  logic [15:0] Start_PC;
  logic [1:0]  Prog_idx;
  logic        Busy;
  logic        Ack;
  logic        Timeout;
  logic [15:0] Cycles;
  logic        All_done;

  modport master (
    output Req, Core_done,
    input  Init, Start_PC, Prog_idx, Busy, Ack, Timeout, Cycles, All_done
  );

  modport slave (
    input  Req, Core_done,
    output Init, Start_PC, Prog_idx, Busy, Ack, Timeout, Cycles, All_done
  );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: steps through a fixed table of programs. For each one it
// loads the start PC, pulses Init to the fetch unit, watches Core_done under a
// watchdog and reports cycle count / status to the harness with a one-cycle Ack.
module prog_sequencer #(
  parameter int          NUM_PROGS   = 3,     // 1..4
  parameter logic [15:0] START_PC0   = 16'd0,
  parameter logic [15:0] START_PC1   = 16'd124,
  parameter logic [15:0] START_PC2   = 16'd301,
  parameter logic [15:0] START_PC3   = 16'd0,
  parameter int          INIT_CYCLES = 2,     // 1..15
  parameter int          TIMEOUT     = 1000   // 1..65535
) (
  input  logic            CLK,
  input  logic            Reset_n,
  prog_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_REPORT,
    S_FINISHED
  } state_t;

  localparam logic [1:0]  LAST_IDX  = 2'(NUM_PROGS - 1);
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      r_state;
  logic [3:0]  r_init_cnt;
  logic [15:0] r_run_cnt;
  logic [1:0]  r_prog_idx;
  logic [15:0] r_cycles;
  logic        r_timeout;
  logic        r_init;
  logic        r_busy;
  logic        r_ack;
  logic        r_all_done;

  logic [15:0] w_run_next;
  logic [15:0] w_start_pc;

  // The first RUN cycle must report as 1, so the compare uses the incremented value.
  assign w_run_next = r_run_cnt + 16'd1;

  // Start PC lookup, decoded from the registered program index only.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    w_start_pc = START_PC0;
    case (r_prog_idx)
      2'd1:    w_start_pc = START_PC1;
      2'd2:    w_start_pc = START_PC2;
      2'd3:    w_start_pc = START_PC3;
      default: w_start_pc = START_PC0;
    endcase
  end

  // Run-control FSM; every output is a register written here.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_init_cnt <= '0;
      r_run_cnt  <= '0;
      r_prog_idx <= '0;
      r_cycles   <= '0;
      r_timeout  <= 1'b0;
      r_init     <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_all_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Req) begin
            r_state    <= S_INIT;
            r_init     <= 1'b1;
            r_busy     <= 1'b1;
            r_init_cnt <= '0;
            r_run_cnt  <= '0;
          end
        end
        // Core_done is ignored here so a sticky DONE from the last program cannot end this one.
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= S_RUN;
            r_init  <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + 4'd1;
          end
        end
        // Core_done takes priority over the watchdog when both hit on the same cycle.
        S_RUN: begin
          r_run_cnt <= w_run_next;
          if (bus.Core_done) begin
            r_cycles  <= w_run_next;
            r_timeout <= 1'b0;
            r_ack     <= 1'b1;
            r_state   <= S_REPORT;
          end else if (w_run_next == TIMEOUT_W) begin
            r_cycles  <= TIMEOUT_W;
            r_timeout <= 1'b1;
            r_ack     <= 1'b1;
            r_state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_busy <= 1'b0;
          if (r_prog_idx == LAST_IDX) begin
            r_all_done <= 1'b1;
            r_state    <= S_FINISHED;
          end else begin
            r_prog_idx <= r_prog_idx + 2'd1;
            r_state    <= S_IDLE;
          end
        end
        S_FINISHED: begin
          r_state <= S_FINISHED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Init     = r_init;
  assign bus.Start_PC = w_start_pc;
  assign bus.Prog_idx = r_prog_idx;
  assign bus.Busy     = r_busy;
  assign bus.Ack      = r_ack;
  assign bus.Timeout  = r_timeout;
  assign bus.Cycles   = r_cycles;
  assign bus.All_done = r_all_done;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed stimulus with a scoreboard. Stimulus pushes the
// expected report and start PC of each launch; a negedge monitor pops and
// compares whenever the DUT raises Init or Ack.
module tb_prog_sequencer;

  typedef struct {
    int cycles;
    bit timeout;
    int idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  int   pc_q[$];
  bit   init_prev;
  int   init_len;

  prog_sequencer_if bus ();

  prog_sequencer #(
    .NUM_PROGS  (3),
    .START_PC0  (16'd0),
    .START_PC1  (16'd124),
    .START_PC2  (16'd301),
    .START_PC3  (16'd0),
    .INIT_CYCLES(2),
    .TIMEOUT    (20)
  ) dut (
    .CLK    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pc_of(input int idx);
    case (idx)
      1:       return 124;
      2:       return 301;
      default: return 0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_init"},     32'(bus.Init),     0);
    check({tag, "_busy"},     32'(bus.Busy),     0);
    check({tag, "_ack"},      32'(bus.Ack),      0);
    check({tag, "_timeout"},  32'(bus.Timeout),  0);
    check({tag, "_all_done"}, 32'(bus.All_done), 0);
    check({tag, "_cycles"},   32'(bus.Cycles),   0);
    check({tag, "_prog_idx"}, 32'(bus.Prog_idx), 0);
    check({tag, "_start_pc"}, 32'(bus.Start_PC), 0);
  endtask

  // Launch one program from a negedge; done_at = RUN cycle Core_done is seen high (0 = never).
  task automatic run_prog(input int done_at, input bit stale, input bit hold_req,
                          input int idx, input int exp_cycles, input bit exp_to);
    exp_t e;
    int   j;
    bit   got;
    e.cycles = exp_cycles;
    e.timeout = exp_to;
    e.idx = idx;
    exp_q.push_back(e);
    pc_q.push_back(pc_of(idx));
    bus.Req = 1'b1;
    bus.Core_done = stale;
    @(posedge clk);
    j = 0;
    got = 1'b0;
    while (!got && j < 200) begin
      @(negedge clk);
      if (!hold_req) bus.Req = 1'b0;
      bus.Core_done = (stale && j < 2) || (done_at > 0 && j >= done_at + 1);
      if (bus.Ack) got = 1'b1;
      j++;
    end
    if (!got) check("ack_wait_expired", 0, 1);
    bus.Core_done = 1'b0;
    @(negedge clk);
    check("ack_single_pulse", 32'(bus.Ack), 0);
    check("busy_after_report", 32'(bus.Busy), 0);
    if (idx == 2) begin
      check("all_done", 32'(bus.All_done), 1);
      check("final_prog_idx", 32'(bus.Prog_idx), 2);
    end else begin
      check("next_prog_idx", 32'(bus.Prog_idx), 32'(idx + 1));
      check("next_start_pc", 32'(bus.Start_PC), 32'(pc_of(idx + 1)));
    end
  endtask

  // Scoreboard monitor: compares Ack reports and Init windows against the queues.
  always @(negedge clk) begin
    exp_t e;
    int   pc;
    if (!rst_n) begin
      init_prev = 1'b0;
      init_len  = 0;
    end else begin
      if (bus.Ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_cycles",   32'(bus.Cycles),   32'(e.cycles));
          check("ack_timeout",  32'(bus.Timeout),  32'(e.timeout));
          check("ack_prog_idx", 32'(bus.Prog_idx), 32'(e.idx));
        end
      end
      if (bus.Init && !init_prev) begin
        init_len = 0;
        if (pc_q.size() == 0) begin
          check("unexpected_init", 1, 0);
        end else begin
          pc = pc_q.pop_front();
          check("init_start_pc", 32'(bus.Start_PC), 32'(pc));
        end
      end
      if (bus.Init) init_len++;
      if (!bus.Init && init_prev) check("init_len", 32'(init_len), 2);
      init_prev = bus.Init;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.Req = 1'b0;
    bus.Core_done = 1'b0;
    rst_n = 1'b0;

    // Reset values, held and then released with Req low.
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_vals("rst_idle");
    end

    // Single launch, stale DONE, watchdog expiry.
    run_prog(10, 1'b0, 1'b0, 0, 10, 1'b0);
    run_prog(5,  1'b1, 1'b0, 1, 5,  1'b0);
    run_prog(0,  1'b0, 1'b0, 2, 20, 1'b1);

    // FINISHED: Req ignored, status held.
    bus.Req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("fin_no_init",  32'(bus.Init),     0);
      check("fin_all_done", 32'(bus.All_done), 1);
      check("fin_cycles",   32'(bus.Cycles),   20);
      check("fin_timeout",  32'(bus.Timeout),  1);
    end
    bus.Req = 1'b0;

    // Core_done on the same cycle as the watchdog limit wins.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(20, 1'b0, 1'b0, 0, 20, 1'b0);

    // Asynchronous reset in RUN cycle 4 of program 1: no Ack may follow.
    pc_q.push_back(124);
    bus.Req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Req = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before_reset", 32'(bus.Busy),     1);
    check("mid_idx_before_reset",  32'(bus.Prog_idx), 1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_vals("mid_after");
    end

    // Back-to-back with Req held high.
    run_prog(3, 1'b0, 1'b1, 0, 3, 1'b0);
    run_prog(3, 1'b0, 1'b1, 1, 3, 1'b0);
    run_prog(3, 1'b0, 1'b1, 2, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b2b_no_init",  32'(bus.Init),     0);
      check("b2b_all_done", 32'(bus.All_done), 1);
      check("b2b_prog_idx", 32'(bus.Prog_idx), 2);
    end
    bus.Req = 1'b0;

    check("pending_reports", 32'(exp_q.size()), 0);
    check("pending_inits",   32'(pc_q.size()),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
